// File: rtl/ps2_kbd_dev.sv
// ps2_kbd_dev
//   PS/2 keyboard receiver feeding a small first-word-fall-through scan-code
//   FIFO that the CPU polls over the MIO bus.
//
// Ports
//   clk         system clock, all logic on the rising edge
//   rst         asynchronous, active-low reset
//   ps2_clk     raw keyboard clock pin (asynchronous)
//   ps2_data    raw keyboard data pin (asynchronous)
//   rd          pop strobe, one cycle per byte
//   clr_err     clears the sticky error flags
//   rd_data     FIFO head byte, 8'h00 when empty
//   ready       FIFO not empty
//   count       number of stored bytes
//   overflow    sticky: good byte dropped because the FIFO was full
//   parity_err  sticky: frame failed the odd-parity check
//   frame_err   sticky: bad stop bit or timeout abort
module ps2_kbd_dev #(
    parameter int FIFO_DEPTH = 8,
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 100000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rd,
    input  logic                          clr_err,
    output logic [7:0]                    rd_data,
    output logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          parity_err,
    output logic                          frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_s;
    logic          data_s;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          filt_flip;
    logic          fall;

    state_t        state, state_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shift_reg, shift_nxt;
    logic          par_bit, par_nxt;
    logic [TW-1:0] tmo_cnt, tmo_nxt;
    logic          push;
    logic          perr_evt;
    logic          ferr_evt;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          do_push;
    logic          do_pop;
    logic          ovf_evt;

    // Two-flop synchronizers; both idle high so a reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];

    // The counter tracks how long the synchronized clock has disagreed with the
    // filtered one; any agreeing sample restarts it, so short glitches vanish.
    // The falling-edge event is raised in the same cycle the filtered clock is
    // about to drop, which keeps pin-to-edge latency at 2 + FILTER_LEN.
    assign filt_flip = (clk_s != filt_clk) && (filt_cnt == FW'(FILTER_LEN - 1));
    assign fall      = filt_flip && filt_clk;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s == filt_clk) begin
            filt_cnt <= '0;
        end else if (filt_flip) begin
            filt_clk <= clk_s;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bit_idx   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            bit_idx   <= bit_idx_nxt;
            shift_reg <= shift_nxt;
            par_bit   <= par_nxt;
            tmo_cnt   <= tmo_nxt;
        end
    end

    // Next-state logic. The timeout counter measures the gap since the last
    // accepted falling edge; an expired gap outside IDLE aborts the frame.
    // Data bits enter at the MSB and shift down, so the first (LSB) bit ends at bit 0.
    always_comb begin
        state_nxt   = state;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift_reg;
        par_nxt     = par_bit;
        push        = 1'b0;
        perr_evt    = 1'b0;
        ferr_evt    = 1'b0;

        if (state == IDLE || fall) begin
            tmo_nxt = '0;
        end else begin
            tmo_nxt = tmo_cnt + TW'(1);
        end

        if (state != IDLE && !fall && tmo_cnt == TW'(TIMEOUT - 1)) begin
            state_nxt = IDLE;
            ferr_evt  = 1'b1;
            tmo_nxt   = '0;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!data_s) begin
                        state_nxt   = DATA;
                        bit_idx_nxt = '0;
                    end
                end
                DATA: begin
                    shift_nxt   = {data_s, shift_reg[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = PARITY;
                    end
                end
                PARITY: begin
                    par_nxt   = data_s;
                    state_nxt = STOP;
                end
                STOP: begin
                    state_nxt = IDLE;
                    perr_evt  = !(^shift_reg ^ par_bit);
                    ferr_evt  = !data_s;
                    push      = data_s && (^shift_reg ^ par_bit);
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
    assign empty   = (count == '0);
    assign full    = (count == (AW + 1)'(FIFO_DEPTH));
    assign do_pop  = rd && !empty;
    assign do_push = push && (!full || do_pop);
    assign ovf_evt = push && full && !do_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW + 1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end

    // Storage is left unreset; the count gates what is visible on rd_data.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= shift_reg;
        end
    end

    assign rd_data = empty ? 8'h00 : mem[rd_ptr];
    assign ready   = !empty;

    // Sticky flags: a new error event takes priority over a coincident clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (perr_evt) begin
                parity_err <= 1'b1;
            end else if (clr_err) begin
                parity_err <= 1'b0;
            end
            if (ferr_evt) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ps2_kbd_dev.md
# ps2_kbd_dev

PS/2 keyboard receiver with an 8-entry scan-code FIFO. It is the input-side counterpart to the VGA text console: key scan codes flow from the keyboard pins toward the CPU. The block sits on the I/O clock domain as a memory-mapped peripheral behind the MIO bus. The CPU polls `ready`, reads the head byte on `rd_data`, and pops it with a one-cycle `rd` strobe.

## Interface

- `FIFO_DEPTH`, default 8: scan-code FIFO entries; must be a power of 2, ≥2.
- `FILTER_LEN`, default 4: consecutive identical samples required before the filtered PS/2 clock changes.
- `TIMEOUT`, default 100000: cycles without an accepted falling edge before a partial frame is aborted.

- `clk` in 1: system clock; all logic is on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `ps2_clk` in 1: raw keyboard clock pin, asynchronous.
- `ps2_data` in 1: raw keyboard data pin, asynchronous.
- `rd` in 1: pop strobe, one cycle per byte.
- `clr_err` in 1: clears the sticky error flags.
- `rd_data` out 8: FIFO head byte; 8'h00 when empty.
- `ready` out 1: FIFO not empty.
- `count` out log2(FIFO_DEPTH)+1: number of stored bytes.
- `overflow` out 1: sticky; a good byte was dropped because the FIFO was full.
- `parity_err` out 1: sticky; a frame failed the odd-parity check.
- `frame_err` out 1: sticky; bad stop bit or timeout abort.

## Operation

- Both pins pass through 2-flop synchronizers.
- Glitch filter:
  - Filtered clock takes the synchronized value only after `FILTER_LEN` consecutive equal samples.
  - A falling edge is the filtered clock going 1→0.
  - Filtered clock resets to 1.
- Frame format: 11 bits sampled on filtered falling edges, in this order: start (0), 8 data bits LSB first, odd parity, stop (1).
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a falling edge with data=0, go to DATA and set the bit index to 0. A falling edge with data=1 is ignored; stay in IDLE.
  - DATA: shift data in LSB first. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: on a falling edge, check the frame and go to IDLE.
    - Stop=1 and parity OK (XOR of data and parity bit = 1): push the byte.
    - Parity bad: no push; set `parity_err`.
    - Stop=0: no push; set `frame_err`.
    - Both bad: set both flags.
- Timeout:
  - The cycle counter clears on every filtered falling edge and is held at 0 in IDLE.
  - In any non-IDLE state, reaching `TIMEOUT` cycles returns the FSM to IDLE, discards the partial byte, and sets `frame_err`.
- FIFO: first-word-fall-through circular buffer with wrapping read and write pointers.
  - Push when full: the byte is dropped and `overflow` is set. FIFO contents are unchanged.
  - Pop (`rd`=1) when empty: ignored, no state change.
  - Push and pop in the same cycle while full: both take effect, `count` stays at `FIFO_DEPTH`, and `overflow` is not set.
  - Push and pop in the same cycle otherwise: `count` is unchanged.
- Sticky flags:
  - `clr_err`=1 clears all three flags.
  - If `clr_err` coincides with a new error event, the event wins and the flag is set.

## Timing

- Reset values:
  - All outputs are 0, and `rd_data` = 8'h00.
  - FSM is in IDLE; pointers, `count` and the timeout counter are 0.
  - Filtered clock and synchronizers hold 1.
- Pin-to-internal-edge latency is 2 + `FILTER_LEN` cycles.
- Push happens in the cycle the stop-bit falling edge is detected. `ready`, `count` and `rd_data` update on the next rising edge.
- `rd` sampled at edge N: `rd_data` shows the next entry (or 8'h00) and `count` decrements after edge N. Back-to-back `rd` pops one byte per cycle.
- Reset asserted mid-frame or with data in the FIFO: everything clears immediately, asynchronously. The first frame after reset release must start from a fresh start bit.

## Test plan

- Send frame 0x1C (parity bit 0, stop 1) at a 60 µs bit period. Expect: `ready`=1, `count`=1, `rd_data`=8'h1C, no errors. Pulse `rd`, then expect `ready`=0 and `rd_data`=8'h00.
- Send 0x1C with parity bit 1. Expect: `parity_err`=1, `count`=0. Pulse `clr_err`, then expect `parity_err`=0.
- Send 9 frames 0x01…0x09 with no reads. Expect: `count`=8, `overflow`=1, and popping in order returns 0x01…0x08.
- Inject a 2-cycle low glitch on `ps2_clk` in IDLE and mid-frame (`FILTER_LEN`=4). Expect no bit to be taken; the following frame 0xF0 (parity 1) is received correctly.
- Send start plus 3 data bits, then hold the clock high for `TIMEOUT`+10 cycles. Expect `frame_err`=1 and FSM in IDLE. A following frame 0x5A (parity 1) must yield `rd_data`=8'h5A.
- Fill the FIFO to 8 entries, then pulse `rd` in the same cycle as the 9th byte's push. Expect `count`=8, `overflow`=0, and the 9th byte stored last.
